// File: rtl/conv_mac_if.sv
// conv_mac_if: operand and result valid/ready streams of conv_mac_ctrl
//   in_valid/in_ready/act/wgt      operand pair stream into the sequencer
//   out_valid/out_ready/out_data/ovf  saturated result stream out of the sequencer
//   master: producer/consumer side, slave: conv_mac_ctrl side
interface conv_mac_if #(
    parameter int W = 16
);
    logic in_valid, in_ready, out_valid, out_ready, ovf;
    logic signed [W-1:0] act, wgt, out_data;
    modport master (output in_valid, act, wgt, out_ready, input in_ready, out_valid, out_data, ovf);
    modport slave (input in_valid, act, wgt, out_ready, output in_ready, out_valid, out_data, ovf);
endinterface

// File: rtl/conv_mac_ctrl.sv
// conv_mac_ctrl: shared-multiplier fixed-point dot product (one window plus bias) with saturated result
//   clk, rst_n   clock, asynchronous active-low reset
//   start, bias  begin a window in IDLE, bias captured with the accepted start
//   clear        synchronous abort to IDLE, no result emitted
//   busy         high whenever a window is in progress
//   bus          operand pair stream in, saturated result stream out
module conv_mac_ctrl #(
    parameter int INT_DIGIT = 11,
    parameter int DECIMAL_DIGIT = 5,
    parameter int KERNEL_LEN = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic signed [INT_DIGIT+DECIMAL_DIGIT-1:0] bias,
    output logic busy,
    conv_mac_if.slave bus
);
    localparam int W = INT_DIGIT + DECIMAL_DIGIT;
    localparam int CNT_W = $clog2(KERNEL_LEN + 1);
    localparam int ACC_W = W + CNT_W;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0] state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [2*W-1:0] full;
    logic signed [W-1:0] prod, prod_r, out_data_r, sat;
    logic prod_v, ovf_r, hs, clamp;
    assign hs = state == LOAD && bus.in_valid;
    assign full = (2*W)'(bus.act) * (2*W)'(bus.wgt);
    // Keep bits [INT+2*DEC-1:DEC] of the full product: floor shift, wrapping truncation
    assign prod = W'(full >>> DECIMAL_DIGIT);
    assign acc_nxt = prod_v ? acc + ACC_W'(prod_r) : acc;
    // Result fits in W bits only when all bits above the W-bit sign position agree
    assign clamp = !(&acc_nxt[ACC_W-1:W-1] || ~|acc_nxt[ACC_W-1:W-1]);
    assign sat = clamp ? {acc_nxt[ACC_W-1], {(W-1){~acc_nxt[ACC_W-1]}}} : acc_nxt[W-1:0];
    assign state_nxt = state == IDLE ? (start ? LOAD : IDLE) :
                       state == LOAD ? (hs && cnt == CNT_W'(KERNEL_LEN - 1) ? DRAIN : LOAD) :
                       state == DRAIN ? DONE : (bus.out_ready ? IDLE : DONE);
    assign bus.in_ready = state == LOAD;
    assign bus.out_valid = state == DONE;
    assign bus.out_data = out_data_r;
    assign bus.ovf = ovf_r;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            prod_r <= '0;
            prod_v <= 1'b0;
            out_data_r <= '0;
            ovf_r <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            prod_v <= 1'b0;
        end else begin
            state <= state_nxt;
            prod_v <= hs;
            if (hs) prod_r <= prod;
            cnt <= state == IDLE ? '0 : hs ? cnt + CNT_W'(1) : cnt;
            acc <= state == IDLE && start ? ACC_W'(bias) : acc_nxt;
            // The last product lands during DRAIN, so the clamp sees the complete sum
            if (state == DRAIN) begin
                out_data_r <= sat;
                ovf_r <= clamp;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_ctrl.sv
// tb_conv_mac_ctrl: directed windows checked against a sum/clamp model and hand-computed results
module tb_conv_mac_ctrl;
    localparam int W = 16, DEC = 5, K = 3;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0, busy;
    logic signed [W-1:0] bias = '0;
    int checks = 0, failures = 0, cyc = 0, s = 0, at = 0;
    bit m_busy;
    int m_taken, m_last;
    longint m_sum;

    conv_mac_if #(.W(W)) bus ();
    conv_mac_ctrl #(.INT_DIGIT(11), .DECIMAL_DIGIT(DEC), .KERNEL_LEN(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .bias(bias), .busy(busy), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int fmul(input int a, input int w);
        longint p;
        logic signed [W-1:0] t;
        p = (longint'(a) * longint'(w)) >>> DEC;
        t = W'(p);
        return int'(t);
    endfunction

    function automatic longint clamp_of(input longint v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    // Model: a window is open from start until its result is taken; it sums bias plus K products
    // and presents the clamped sum from the second edge after the last pair onward.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_taken <= 0;
            m_last <= 0;
            m_sum <= 0;
        end else if (clear) m_busy <= 1'b0;
        else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_taken <= 0;
                m_sum <= longint'(bias);
            end
        end else if (m_taken < K) begin
            if (bus.in_valid) begin
                m_sum <= m_sum + fmul(bus.act, bus.wgt);
                m_taken <= m_taken + 1;
                if (m_taken == K - 1) m_last <= cyc + 1;
            end
        end else if (cyc >= m_last + 1 && bus.out_ready) m_busy <= 1'b0;
    end

    always @(negedge clk) begin
        logic ov;
        ov = m_busy && m_taken == K && cyc >= m_last + 1;
        chk("ctrl{busy,in_ready,out_valid}", {busy, bus.in_ready, bus.out_valid}, {m_busy, m_busy && m_taken < K, ov});
        if (ov) begin
            chk("model out_data", bus.out_data, clamp_of(m_sum));
            chk("model ovf", bus.ovf, clamp_of(m_sum) != m_sum);
        end
        if (!rst_n) chk("reset out_data/ovf", {bus.out_data, bus.ovf}, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        bias = W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int a, input int w, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.act = W'($urandom);
            bus.wgt = W'($urandom);
            step();
        end
        bus.in_valid = 1'b1;
        bus.act = W'(a);
        bus.wgt = W'(w);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input int hold, input bit pulse, input int exp_d, input bit exp_o,
                              input string name, output int seen);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        seen = cyc;
        chk({name, " out_valid"}, bus.out_valid, 1);
        chk({name, " out_data"}, bus.out_data, exp_d);
        chk({name, " ovf"}, bus.ovf, exp_o);
        for (int i = 0; i < hold; i++) begin
            start = pulse && i == 1;
            step();
            start = 1'b0;
            chk({name, " hold out_data"}, bus.out_data, exp_d);
            chk({name, " hold ovf"}, bus.ovf, exp_o);
            chk({name, " hold valid/busy"}, {bus.out_valid, busy}, 2'b11);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({name, " released"}, {bus.out_valid, busy}, 2'b00);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.act = '0;
        bus.wgt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/in_ready/out_valid", {busy, bus.in_ready, bus.out_valid}, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset ovf", bus.ovf, 0);
        rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.act = 16'sd5;
        bus.wgt = 16'sd5;
        step();
        bus.in_valid = 1'b0;
        chk("idle in_valid ignored", {busy, bus.in_ready}, 0);

        do_start(0);
        s = cyc;
        chk("start busy/in_ready", {busy, bus.in_ready}, 2'b11);
        repeat (K) send(32, 64, 0);
        chk("drain in_ready low", {busy, bus.in_ready, bus.out_valid}, 3'b100);
        get_result(0, 1'b0, 192, 1'b0, "basic", at);
        chk("basic latency edges", at - s, K + 1);

        do_start(0);
        repeat (K) send(1000, 1000, 0);
        get_result(0, 1'b0, 32767, 1'b1, "pos_sat", at);

        do_start(-32768);
        repeat (K) send(-32, 32, 0);
        get_result(0, 1'b0, -32768, 1'b1, "neg_sat", at);

        do_start(100);
        repeat (K) send(-32, 32, 0);
        get_result(0, 1'b0, 4, 1'b0, "bias100", at);

        do_start(0);
        repeat (K) send(32, 64, $urandom_range(0, 3));
        get_result(5, 1'b1, 192, 1'b0, "stall", at);

        do_start(0);
        repeat (2) send(32, 64, 0);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.act = 16'sd32;
        bus.wgt = 16'sd64;
        step();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear to idle", {busy, bus.in_ready, bus.out_valid}, 0);
        repeat (4) step();
        chk("clear no result", bus.out_valid, 0);

        do_start(0);
        repeat (K) send(32, 32, 0);
        get_result(0, 1'b0, 96, 1'b0, "after_clear", at);

        do_start(0);
        send(32, 64, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset ctrl", {busy, bus.in_ready, bus.out_valid}, 0);
        chk("async reset out_data", bus.out_data, 0);
        chk("async reset ovf", bus.ovf, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_start(0);
        repeat (K) send(-1, 1, 0);
        get_result(0, 1'b0, -3, 1'b0, "trunc", at);
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
